// File: rtl/seat_alloc.sv
// Seat allocation controller: books seats by round-robin scan over a req/ack
// handshake, frees seats on release strobes and drives the occupancy vector.
module seat_alloc #(
    parameter int unsigned NSEAT = 5,
    localparam int unsigned IW = $clog2(NSEAT),
    localparam int unsigned CW = $clog2(NSEAT + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_book,
    output logic             o_book_ack,
    output logic [IW-1:0]    o_book_seat,
    input  logic             i_release,
    input  logic [IW-1:0]    i_release_seat,
    output logic [NSEAT-1:0] o_seat,
    output logic             o_full,
    output logic [CW-1:0]    o_count,
    output logic             o_err
);

    typedef enum logic [1:0] {StIdle, StScan, StAck, StWait} state_t;

    localparam logic [NSEAT-1:0] OneHot0 = {{(NSEAT-1){1'b0}}, 1'b1};

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    ptr_inc;
    logic [NSEAT-1:0] rel_mask;
    logic [NSEAT-1:0] grant_mask;
    logic [NSEAT-1:0] seat_next;
    logic             rel_hit;
    logic             rel_err;
    logic             book_reject;
    logic             grant;

    // Release/grant decode and next occupancy; an out-of-range release index
    // shifts the mask to zero, so it can never hit and is reported as an error.
    always_comb begin
        rel_mask    = OneHot0 << i_release_seat;
        grant_mask  = OneHot0 << ptr;
        rel_hit     = i_release && (|(o_seat & rel_mask));
        rel_err     = i_release && !rel_hit;
        book_reject = (state == StIdle) && i_book && o_full;
        grant       = (state == StScan) && !o_seat[ptr];
        ptr_inc     = (ptr == IW'(NSEAT - 1)) ? '0 : ptr + 1'b1;
        seat_next   = (o_seat & ~(rel_hit ? rel_mask : '0)) | (grant ? grant_mask : '0);
    end

    // Status outputs derived from the registered occupancy vector.
    always_comb begin
        o_full  = &o_seat;
        o_count = '0;
        for (int n = 0; n < NSEAT; n++) begin
            o_count = o_count + CW'(o_seat[n]);
        end
        o_book_ack = (state == StAck);
    end

    // Booking FSM, occupancy register and error pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= StIdle;
            ptr         <= '0;
            o_seat      <= '0;
            o_book_seat <= '0;
            o_err       <= 1'b0;
        end else begin
            o_seat <= seat_next;
            o_err  <= rel_err | book_reject;
            unique case (state)
                StIdle: begin
                    if (i_book && !o_full) state <= StScan;
                end
                StScan: begin
                    ptr <= ptr_inc;
                    if (grant) begin
                        o_book_seat <= ptr;
                        state       <= StAck;
                    end
                end
                StAck: begin
                    state <= StWait;
                end
                StWait: begin
                    // Hold until the request drops so one request books once.
                    if (!i_book) state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seat_alloc.sv
// Self-checking bench for seat_alloc: per-cycle compare against a behavioural
// seat model plus directed literal checks of grants, latencies and errors.
module tb_seat_alloc;

    localparam int NSEAT = 5;
    localparam int IW    = 3;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             book = 1'b0;
    logic             rel = 1'b0;
    logic [IW-1:0]    rel_seat = '0;
    logic             ack;
    logic [IW-1:0]    bseat;
    logic [NSEAT-1:0] seat;
    logic             full;
    logic [CW-1:0]    count;
    logic             err;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    seat_alloc #(.NSEAT(NSEAT)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_book         (book),
        .o_book_ack     (ack),
        .o_book_seat    (bseat),
        .i_release      (rel),
        .i_release_seat (rel_seat),
        .o_seat         (seat),
        .o_full         (full),
        .o_count        (count),
        .o_err          (err)
    );

    always #5 clk = ~clk;

    // Behavioural model: a set of taken seats, a round-robin start pointer
    // and the phase of the current booking.
    localparam int PIdle = 0;
    localparam int PScan = 1;
    localparam int PAck  = 2;
    localparam int PWait = 3;

    bit [NSEAT-1:0] m_seat;
    int             m_ptr;
    int             m_phase;
    int             m_bseat;
    bit             m_err;

    function automatic int taken(input bit [NSEAT-1:0] s);
        int c = 0;
        for (int n = 0; n < NSEAT; n++) c += int'(s[n]);
        return c;
    endfunction

    always @(posedge clk) begin : model
        bit [NSEAT-1:0] old;
        bit             e;
        int             ri;
        if (rst) begin
            m_seat  = '0;
            m_ptr   = 0;
            m_phase = PIdle;
            m_bseat = 0;
            m_err   = 1'b0;
        end else begin
            old = m_seat;
            e   = 1'b0;
            ri  = int'(rel_seat);
            if (rel) begin
                if (ri >= NSEAT) e = 1'b1;
                else if (!old[ri]) e = 1'b1;
                else m_seat[ri] = 1'b0;
            end
            case (m_phase)
                PIdle: if (book) begin
                    if (taken(old) == NSEAT) e = 1'b1;
                    else m_phase = PScan;
                end
                PScan: begin
                    if (!old[m_ptr]) begin
                        m_seat[m_ptr] = 1'b1;
                        m_bseat       = m_ptr;
                        m_phase       = PAck;
                    end
                    m_ptr = (m_ptr + 1) % NSEAT;
                end
                PAck:  m_phase = PWait;
                default: if (!book) m_phase = PIdle;
            endcase
            m_err = e;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (checking) begin
            tests++;
            if (seat !== m_seat || count !== CW'(taken(m_seat)) ||
                full !== (taken(m_seat) == NSEAT) || ack !== (m_phase == PAck) ||
                bseat !== IW'(m_bseat) || err !== m_err) begin
                fails++;
                $display("FAIL model_cycle t=%0t seat=%b/%b count=%0d/%0d full=%b/%b ack=%b/%b bseat=%0d/%0d err=%b/%b (got/required)",
                         $time, seat, m_seat, count, taken(m_seat), full,
                         taken(m_seat) == NSEAT, ack, m_phase == PAck, bseat, m_bseat, err, m_err);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got=%0d required=%0d", name, act, exp);
        end
    endtask

    // Raise a booking request, optionally drive a release at cycle rel_at,
    // and report the ack latency in cycles and the granted seat.
    task automatic book_req(input int rel_at, input int rs, output int lat, output int gs);
        book = 1'b1;
        lat  = 0;
        gs   = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rel_at != 0 && i == rel_at) begin
                rel      = 1'b1;
                rel_seat = IW'(rs);
            end else begin
                rel = 1'b0;
            end
            if (ack) begin
                lat = i;
                gs  = int'(bseat);
                break;
            end
        end
        book = 1'b0;
        rel  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_seat(input int s, output int e);
        rel      = 1'b1;
        rel_seat = IW'(s);
        @(negedge clk);
        rel = 1'b0;
        e   = int'(err);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int gs;
        int e;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        checking = 1'b1;
        chk("reset_seat", int'(seat), 0);
        chk("reset_count", int'(count), 0);
        chk("reset_full", int'(full), 0);
        chk("reset_ack", int'(ack), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_bseat", int'(bseat), 0);

        // Five bookings fill the seats in order.
        for (int b = 0; b < NSEAT; b++) begin
            book_req(0, 0, lat, gs);
            chk("fill_latency", lat, 2);
            chk("fill_seat", gs, b);
        end
        chk("full_seat", int'(seat), 5'b11111);
        chk("full_flag", int'(full), 1);
        chk("full_count", int'(count), 5);

        // Booking while full: error every IDLE cycle, never an ack.
        book = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reject_err", int'(err), 1);
            chk("reject_ack", int'(ack), 0);
        end
        book = 1'b0;
        @(negedge clk);
        chk("reject_err_end", int'(err), 0);
        chk("reject_seat", int'(seat), 5'b11111);

        // Free seat 2, then rebook: scan skips 0 and 1.
        release_seat(2, e);
        chk("rel2_err", e, 0);
        chk("rel2_seat", int'(seat), 5'b11011);
        chk("rel2_count", int'(count), 4);
        book_req(0, 0, lat, gs);
        chk("rebook_latency", lat, 4);
        chk("rebook_seat", gs, 2);
        chk("rebook_full", int'(seat), 5'b11111);

        // Out-of-range and already-free releases.
        release_seat(6, e);
        chk("rel6_err", e, 1);
        chk("rel6_seat", int'(seat), 5'b11111);
        release_seat(1, e);
        chk("rel1_err", e, 0);
        release_seat(1, e);
        chk("rel1_again_err", e, 1);
        chk("rel1_seat", int'(seat), 5'b11101);

        // Ptr is 3: scan skips 3,4,0 and grants 1 while seat 4 is released.
        book_req(4, 4, lat, gs);
        chk("overlap_latency", lat, 5);
        chk("overlap_seat", gs, 1);
        chk("overlap_vec", int'(seat), 5'b01111);
        chk("overlap_count", int'(count), 4);

        // Reset while scanning aborts the booking.
        book = 1'b1;
        @(negedge clk);
        rst  = 1'b1;
        book = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_scan_ack", int'(ack), 0);
        chk("rst_scan_seat", int'(seat), 0);
        @(negedge clk);
        chk("rst_scan_ack2", int'(ack), 0);
        book_req(0, 0, lat, gs);
        chk("after_rst_latency", lat, 2);
        chk("after_rst_seat", gs, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
